data_mem_req: RTL
=================

# data_mem_req

Request side of the data-memory interface for the dual-issue pipeline. It sits between EX/MEM and the data SRAM-like bus, alongside the MEM stage that consumes load data. It turns the slot-1 memory operation into one bus transaction: byte strobes, store-data lane alignment, and an address/data handshake. It returns the raw load word to the MEM stage as `mem_data_o`/`mem_data_valid_o` and stalls the pipeline while a transaction is in flight.

## Interface
- No parameters; widths come from `defines.v` (`RegBus`=32, `AluOpBus`).
- `clk` in 1 — clock.
- `rst` in 1 — asynchronous reset, active-low.
- `req_valid_i` in 1 — a valid slot-1 instruction is present in MEM (not a bubble).
- `aluop_i` in `AluOpBus` — slot-1 aluop; memory ops are LB/LBU/LH/LHU/LW/LWL/LWR/LL/SB/SH/SW/SWL/SWR/SC.
- `mem_addr_i` in 32 — effective address.
- `reg2_i` in 32 — store source register.
- `LLbit_i` in 1 — current LL bit, already forwarded.
- `exception_i` in 1 — slot-1 carries an exception; the access must not issue.
- `flush_i` in 1 — pipeline flush.
- `stall_i` in 1 — downstream stall; MEM holds its contents.
- `data_req_o` out 1 — bus request.
- `data_wr_o` out 1 — 1 = store.
- `data_size_o` out 2 — 0 = byte, 1 = half, 2 = word.
- `data_wstrb_o` out 4 — byte strobes; lane 0 = bits 7:0.
- `data_addr_o` out 32 — bus address.
- `data_wdata_o` out 32 — lane-aligned store data.
- `data_addr_ok_i` in 1 — request accepted this cycle.
- `data_data_ok_i` in 1 — response this cycle (read data or write ack).
- `data_rdata_i` in 32 — read data.
- `mem_data_o` out 32 — captured read word, unaligned; extraction happens in MEM.
- `mem_data_valid_o` out 1 — `mem_data_o` is valid for the current MEM instruction.
- `stall_req_o` out 1 — stall request to the pipeline controller.

## Operation
- `issue` = IDLE & `req_valid_i` & memory aluop & !`exception_i` & !`flush_i` & !(SC & !`LLbit_i`).
- An SC with `LLbit_i`=0 issues nothing and raises no stall.
- Request fields are latched at issue and held constant until `data_addr_ok_i`.
- Loads:
  - `data_wr_o`=0, `data_wstrb_o`=0000.
  - Address `{addr[31:2],2'b00}`, size 2 for every load type. MEM selects bytes using `mem_addr[1:0]`.
- SB: size 0, address unchanged, strobe `1<<addr[1:0]`, wdata `{4{reg2[7:0]}}`.
- SH: size 1, strobe 0011 if addr[1]=0 else 1100, wdata `{2{reg2[15:0]}}`.
- SW/SC: size 2, strobe 1111, wdata `reg2`.
- SWL (addr[1:0] 00/01/10/11):
  - strobe 0001/0011/0111/1111
  - wdata `{24'b0,reg2[31:24]}` / `{16'b0,reg2[31:16]}` / `{8'b0,reg2[31:8]}` / `reg2`
- SWR (addr[1:0] 00/01/10/11):
  - strobe 1111/1110/1100/1000
  - wdata `reg2` / `{reg2[23:0],8'b0}` / `{reg2[15:0],16'b0}` / `{reg2[7:0],24'b0}`
- SWL/SWR use size 2 and a word-aligned address.
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL.
  - IDLE: issue → REQ.
  - REQ (`data_req_o`=1):
    - `flush_i` & !addr_ok → IDLE.
    - addr_ok & data_ok → DONE.
    - addr_ok → WAIT, or CANCEL if `flush_i`.
  - WAIT:
    - data_ok → DONE, or IDLE if `flush_i`.
    - `flush_i` without data_ok → CANCEL.
  - DONE: `stall_i` & !`flush_i` → DONE; otherwise → IDLE.
  - CANCEL: data_ok → IDLE; the response is discarded.
- `mem_data_o` captures `data_rdata_i` on a data_ok that leads to DONE, for loads only. It is held until the next capture.
- `mem_data_valid_o` = (state==DONE) & latched op is a load.
- `stall_req_o` = issue | REQ | WAIT | CANCEL. It is 0 in DONE, so the instruction advances at the end of DONE unless `stall_i` is set.
- While in CANCEL, a new valid request is not issued and `stall_req_o`=1.

## Timing
- All outputs are registered, except `stall_req_o`, which is combinational from issue and state.
- Reset values:
  - all outputs 0, state IDLE, `mem_data_o`=0;
  - reset mid-transaction returns to IDLE immediately and drops `data_req_o`; the bus side is reset together.
- Best-case load, with addr_ok and data_ok in the same cycle as the first `data_req_o`:
  - T0 issue, stall=1;
  - T1 REQ, stall=1;
  - T2 DONE, `mem_data_valid_o`=1, stall=0;
  - the instruction advances at the end of T2.
- Each wait cycle on addr_ok or data_ok adds one cycle.
- `data_req_o` is never asserted in two consecutive transactions without passing through IDLE. There is at most one outstanding transaction.

## Test plan
- LW at 0x8000_0104, slave responds addr_ok and data_ok together with 0xDEADBEEF:
  - `data_addr_o`=0x8000_0104, size 2, wstrb 0;
  - DONE with `mem_data_o`=0xDEADBEEF, valid for 1 cycle;
  - stall high for 2 cycles.
- SB at address ending in 10, `reg2`=0x0000_00A5: wstrb 0100, wdata 0xA5A5A5A5, size 0, valid never set.
- SWL and SWR at address ending in 01, `reg2`=0x11223344:
  - SWL: wstrb 0011, wdata 0x00001122;
  - SWR: wstrb 1110, wdata 0x22334400.
- Load with addr_ok delayed 3 cycles and data_ok 2 cycles later:
  - `data_req_o` and fields stable for all 4 REQ cycles;
  - stall continuous until DONE.
- `flush_i` in WAIT, then data_ok after 2 cycles:
  - CANCEL state, `mem_data_valid_o` stays 0;
  - a new LW presented meanwhile issues only after return to IDLE.
- Edge cases:
  - SC with `LLbit_i`=0: no `data_req_o`, no stall.
  - `exception_i`=1 on SW: no request.
  - Reset asserted in WAIT: all outputs 0 asynchronously.

Source files
------------

// File: rtl/data_mem_req.sv
// Data-memory request side: turns the slot-1 memory op into one bus
// transaction (strobes, lane-aligned store data, addr/data handshake),
// returns the raw load word to MEM, and stalls the pipeline meanwhile.
module data_mem_req (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        LLbit_i,
  input  logic        exception_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] mem_data_o,
  output logic        mem_data_valid_o,
  output logic        stall_req_o
);

  localparam int unsigned REG_W   = 32;
  localparam int unsigned ALUOP_W = 8;

  localparam logic [ALUOP_W-1:0] OP_LB  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] OP_LBU = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] OP_LH  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] OP_LHU = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] OP_LW  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] OP_LWL = 8'b1110_0010;
  localparam logic [ALUOP_W-1:0] OP_LWR = 8'b1110_0110;
  localparam logic [ALUOP_W-1:0] OP_LL  = 8'b1111_0000;
  localparam logic [ALUOP_W-1:0] OP_SB  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] OP_SH  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] OP_SW  = 8'b1110_1011;
  localparam logic [ALUOP_W-1:0] OP_SWL = 8'b1110_1010;
  localparam logic [ALUOP_W-1:0] OP_SWR = 8'b1110_1110;
  localparam logic [ALUOP_W-1:0] OP_SC  = 8'b1111_1000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_CANCEL = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               data_req_q, data_req_d;
  logic               data_wr_q, data_wr_d;
  logic [1:0]         data_size_q, data_size_d;
  logic [3:0]         data_wstrb_q, data_wstrb_d;
  logic [REG_W-1:0]   data_addr_q, data_addr_d;
  logic [REG_W-1:0]   data_wdata_q, data_wdata_d;
  logic               is_load_q, is_load_d;
  logic [REG_W-1:0]   mem_data_q, mem_data_d;
  logic               mem_data_valid_q, mem_data_valid_d;

  logic               is_mem_c, is_load_c, is_sc_c, wr_c;
  logic [1:0]         size_c;
  logic [3:0]         strb_c;
  logic [REG_W-1:0]   addr_c, wdata_c;
  logic               issue_c;

  // Decode the aluop into bus request fields
  always_comb begin
    is_mem_c  = 1'b0;
    is_load_c = 1'b0;
    is_sc_c   = 1'b0;
    wr_c      = 1'b0;
    size_c    = 2'd2;
    strb_c    = 4'b0000;
    addr_c    = {mem_addr_i[31:2], 2'b00};
    wdata_c   = '0;
    case (aluop_i)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_LL: begin
        is_mem_c  = 1'b1;
        is_load_c = 1'b1;
      end
      OP_SB: begin
        is_mem_c = 1'b1;
        wr_c     = 1'b1;
        size_c   = 2'd0;
        addr_c   = mem_addr_i;
        strb_c   = 4'(4'b0001 << mem_addr_i[1:0]);
        wdata_c  = {4{reg2_i[7:0]}};
      end
      OP_SH: begin
        is_mem_c = 1'b1;
        wr_c     = 1'b1;
        size_c   = 2'd1;
        addr_c   = mem_addr_i;
        strb_c   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{reg2_i[15:0]}};
      end
      OP_SW, OP_SC: begin
        is_mem_c = 1'b1;
        is_sc_c  = (aluop_i == OP_SC);
        wr_c     = 1'b1;
        addr_c   = mem_addr_i;
        strb_c   = 4'b1111;
        wdata_c  = reg2_i;
      end
      OP_SWL: begin
        is_mem_c = 1'b1;
        wr_c     = 1'b1;
        case (mem_addr_i[1:0])
          2'b00:   begin strb_c = 4'b0001; wdata_c = {24'b0, reg2_i[31:24]}; end
          2'b01:   begin strb_c = 4'b0011; wdata_c = {16'b0, reg2_i[31:16]}; end
          2'b10:   begin strb_c = 4'b0111; wdata_c = {8'b0, reg2_i[31:8]};   end
          default: begin strb_c = 4'b1111; wdata_c = reg2_i;                 end
        endcase
      end
      OP_SWR: begin
        is_mem_c = 1'b1;
        wr_c     = 1'b1;
        case (mem_addr_i[1:0])
          2'b00:   begin strb_c = 4'b1111; wdata_c = reg2_i;                 end
          2'b01:   begin strb_c = 4'b1110; wdata_c = {reg2_i[23:0], 8'b0};  end
          2'b10:   begin strb_c = 4'b1100; wdata_c = {reg2_i[15:0], 16'b0}; end
          default: begin strb_c = 4'b1000; wdata_c = {reg2_i[7:0], 24'b0};  end
        endcase
      end
      default: ;
    endcase
  end

  // A new transaction starts only from IDLE; failed SC issues nothing
  assign issue_c = (state_q == S_IDLE) & req_valid_i & is_mem_c & ~exception_i
                 & ~flush_i & ~(is_sc_c & ~LLbit_i);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic for the bus handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue_c) state_d = S_REQ;
      S_REQ: begin
        if (data_addr_ok_i) begin
          if (data_data_ok_i) state_d = S_DONE;
          else if (flush_i)   state_d = S_CANCEL;
          else                state_d = S_WAIT;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok_i) state_d = flush_i ? S_IDLE : S_DONE;
        else if (flush_i)   state_d = S_CANCEL;
      end
      S_DONE:   if (!(stall_i && !flush_i)) state_d = S_IDLE;
      S_CANCEL: if (data_data_ok_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and latched request fields
  always_comb begin
    data_wr_d        = data_wr_q;
    data_size_d      = data_size_q;
    data_wstrb_d     = data_wstrb_q;
    data_addr_d      = data_addr_q;
    data_wdata_d     = data_wdata_q;
    is_load_d        = is_load_q;
    mem_data_d       = mem_data_q;
    data_req_d       = (state_d == S_REQ);
    mem_data_valid_d = (state_d == S_DONE) & is_load_q;
    if (issue_c) begin
      data_wr_d    = wr_c;
      data_size_d  = size_c;
      data_wstrb_d = strb_c;
      data_addr_d  = addr_c;
      data_wdata_d = wdata_c;
      is_load_d    = is_load_c;
    end
    if ((state_d == S_DONE) && (state_q != S_DONE) && is_load_q)
      mem_data_d = data_rdata_i;
  end

  // Output and field registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_req_q       <= 1'b0;
      data_wr_q        <= 1'b0;
      data_size_q      <= 2'd0;
      data_wstrb_q     <= 4'b0000;
      data_addr_q      <= '0;
      data_wdata_q     <= '0;
      is_load_q        <= 1'b0;
      mem_data_q       <= '0;
      mem_data_valid_q <= 1'b0;
    end else begin
      data_req_q       <= data_req_d;
      data_wr_q        <= data_wr_d;
      data_size_q      <= data_size_d;
      data_wstrb_q     <= data_wstrb_d;
      data_addr_q      <= data_addr_d;
      data_wdata_q     <= data_wdata_d;
      is_load_q        <= is_load_d;
      mem_data_q       <= mem_data_d;
      mem_data_valid_q <= mem_data_valid_d;
    end
  end

  assign data_req_o       = data_req_q;
  assign data_wr_o        = data_wr_q;
  assign data_size_o      = data_size_q;
  assign data_wstrb_o     = data_wstrb_q;
  assign data_addr_o      = data_addr_q;
  assign data_wdata_o     = data_wdata_q;
  assign mem_data_o       = mem_data_q;
  assign mem_data_valid_o = mem_data_valid_q;
  assign stall_req_o      = issue_c | (state_q == S_REQ) | (state_q == S_WAIT)
                          | (state_q == S_CANCEL);

endmodule
